// File: rtl/div_pkg.sv
// div_pkg: definitions shared by the restoring-divider result stage.
//   - Default operand width and BCD digit count, shared with the divider datapath.
//   - State encoding for the BCD result FSM.
//   - BLANK_DIGIT: the nibble the display driver shows as blank.
//   - pow10(): helper for the elaboration-time digit-count check.
`timescale 1ns/1ps
package div_pkg;

  localparam int unsigned DIV_WIDTH  = 4;
  localparam int unsigned DIV_DIGITS = 2;

  localparam logic [3:0] BLANK_DIGIT = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_CONV_Q = 2'b01,
    S_CONV_R = 2'b10,
    S_FINISH = 2'b11
  } state_t;

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned p;
    p = 1;
    for (int unsigned i = 0; i < n; i++) begin
      p = p * 10;
    end
    return p;
  endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// bcd_dabble_step: one combinational shift-and-add-3 (double dabble) step.
// Ports:
//   i_scratch  DIGITS packed BCD digits accumulated so far (digit 0 in [3:0])
//   i_bit      next binary bit, MSB first
//   o_scratch  digits corrected (+3 where >= 5), then shifted left with i_bit in
`timescale 1ns/1ps
module bcd_dabble_step #(
  parameter int unsigned DIGITS = 2
) (
  input  logic [4*DIGITS-1:0] i_scratch,
  input  logic                i_bit,
  output logic [4*DIGITS-1:0] o_scratch
);

  logic [4*DIGITS-1:0] w_adj;

  always_comb begin
    w_adj = i_scratch;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (i_scratch[4*d +: 4] >= 4'd5) begin
        w_adj[4*d +: 4] = i_scratch[4*d +: 4] + 4'd3;
      end
    end
    o_scratch = {w_adj[4*DIGITS-2:0], i_bit};
  end

endmodule

// File: rtl/div_result_bcd.sv
// div_result_bcd: result stage behind the restoring divider.
// Captures quotient/remainder/error on the divider's done pulse, converts both
// values to packed BCD one bit per cycle, and holds the result for the
// seven-segment driver.
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   done_in   one-cycle completion pulse from divider control
//   error_in  divide-by-zero flag, sampled with done_in
//   quot_in   quotient, sampled with done_in
//   rem_in    remainder, sampled with done_in
//   q_bcd     held packed BCD quotient (digit 0 in [3:0]); all 0xF on error
//   r_bcd     held packed BCD remainder; all 0xF on error
//   err_out   error flag for the held result
//   valid     held result complete and stable
//   busy      conversion in progress
//   overrun   one-cycle pulse: a done_in arrived while busy and was dropped
`timescale 1ns/1ps
module div_result_bcd
  import div_pkg::*;
#(
  parameter int unsigned WIDTH  = DIV_WIDTH,
  parameter int unsigned DIGITS = DIV_DIGITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                done_in,
  input  logic                error_in,
  input  logic [WIDTH-1:0]    quot_in,
  input  logic [WIDTH-1:0]    rem_in,
  output logic [4*DIGITS-1:0] q_bcd,
  output logic [4*DIGITS-1:0] r_bcd,
  output logic                err_out,
  output logic                valid,
  output logic                busy,
  output logic                overrun
);

  localparam int unsigned     BW   = 4 * DIGITS;
  localparam int unsigned     CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam longint unsigned MAXV = (64'd1 << WIDTH) - 64'd1;

  if (pow10(DIGITS) <= MAXV) begin : g_digits_check
    $error("div_result_bcd: DIGITS too small to represent a WIDTH-bit value");
  end

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic            w_cnt_zero;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_rem_hold;
  logic            r_err_hold;
  logic [BW-1:0]   r_scratch;
  logic [BW-1:0]   w_step;
  logic [BW-1:0]   r_q_res;
  logic [BW-1:0]   r_r_res;
  logic [BW-1:0]   r_q_bcd;
  logic [BW-1:0]   r_r_bcd;
  logic            r_err_out;
  logic            r_valid;
  logic            r_busy;
  logic            r_overrun;

  assign w_cnt_zero = (r_cnt == '0);

  // One step unit serves both conversions: the shift register is reloaded with
  // the held remainder when the quotient finishes.
  bcd_dabble_step #(
    .DIGITS (DIGITS)
  ) u_step (
    .i_scratch (r_scratch),
    .i_bit     (r_shift[WIDTH-1]),
    .o_scratch (w_step)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (done_in) begin
          w_next = error_in ? S_FINISH : S_CONV_Q;
        end
      end
      S_CONV_Q: begin
        if (w_cnt_zero) begin
          w_next = S_CONV_R;
        end
      end
      S_CONV_R: begin
        if (w_cnt_zero) begin
          w_next = S_FINISH;
        end
      end
      S_FINISH: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_shift    <= '0;
      r_rem_hold <= '0;
      r_err_hold <= 1'b0;
      r_scratch  <= '0;
      r_q_res    <= '0;
      r_r_res    <= '0;
      r_q_bcd    <= '0;
      r_r_bcd    <= '0;
      r_err_out  <= 1'b0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      // busy is registered from the next state so it tracks the FSM exactly.
      r_busy    <= (w_next != S_IDLE);
      r_overrun <= done_in && (r_state != S_IDLE);

      unique case (r_state)
        S_IDLE: begin
          if (done_in) begin
            r_valid    <= 1'b0;
            r_err_hold <= error_in;
            r_shift    <= quot_in;
            r_rem_hold <= rem_in;
            r_cnt      <= CW'(WIDTH - 1);
            r_scratch  <= '0;
          end
        end
        S_CONV_Q: begin
          if (w_cnt_zero) begin
            r_q_res   <= w_step;
            r_scratch <= '0;
            r_shift   <= r_rem_hold;
            r_cnt     <= CW'(WIDTH - 1);
          end else begin
            r_scratch <= w_step;
            r_shift   <= r_shift << 1;
            r_cnt     <= r_cnt - CW'(1);
          end
        end
        S_CONV_R: begin
          if (w_cnt_zero) begin
            r_r_res   <= w_step;
            r_scratch <= '0;
          end else begin
            r_scratch <= w_step;
            r_shift   <= r_shift << 1;
            r_cnt     <= r_cnt - CW'(1);
          end
        end
        S_FINISH: begin
          if (r_err_hold) begin
            r_q_bcd   <= {DIGITS{BLANK_DIGIT}};
            r_r_bcd   <= {DIGITS{BLANK_DIGIT}};
            r_err_out <= 1'b1;
          end else begin
            r_q_bcd   <= r_q_res;
            r_r_bcd   <= r_r_res;
            r_err_out <= 1'b0;
          end
          r_valid <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign q_bcd   = r_q_bcd;
  assign r_bcd   = r_r_bcd;
  assign err_out = r_err_out;
  assign valid   = r_valid;
  assign busy    = r_busy;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_div_result_bcd.sv
`timescale 1ns/1ps
module tb_div_result_bcd;

  localparam int unsigned W  = 4;
  localparam int unsigned D  = 2;
  localparam int unsigned BW = 4 * D;

  logic          clk;
  logic          rst;
  logic          done_in;
  logic          error_in;
  logic [W-1:0]  quot_in;
  logic [W-1:0]  rem_in;
  logic [BW-1:0] q_bcd;
  logic [BW-1:0] r_bcd;
  logic          err_out;
  logic          valid;
  logic          busy;
  logic          overrun;

  div_result_bcd #(
    .WIDTH  (W),
    .DIGITS (D)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .done_in  (done_in),
    .error_in (error_in),
    .quot_in  (quot_in),
    .rem_in   (rem_in),
    .q_bcd    (q_bcd),
    .r_bcd    (r_bcd),
    .err_out  (err_out),
    .valid    (valid),
    .busy     (busy),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [BW-1:0] to_bcd(input int unsigned v);
    logic [BW-1:0] res;
    int unsigned   x;
    res = '0;
    x   = v;
    for (int unsigned i = 0; i < D; i++) begin
      res[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return res;
  endfunction

  // Behavioural model: a countdown of remaining busy cycles plus a pending
  // result that becomes visible when the countdown expires.
  int            m_rem = 0;
  logic [BW-1:0] m_q, m_r, p_q, p_r;
  logic          m_err, p_err, m_valid, m_busy, m_ovr;
  bit            started = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_rem = 0; m_q = '0; m_r = '0; m_err = 0; m_valid = 0; m_ovr = 0;
    end else begin
      m_ovr = done_in && (m_rem != 0);
      if (m_rem == 0) begin
        if (done_in) begin
          m_valid = 0;
          if (error_in) begin
            p_q = '1; p_r = '1; p_err = 1; m_rem = 1;
          end else begin
            p_q = to_bcd(quot_in); p_r = to_bcd(rem_in); p_err = 0;
            m_rem = 2 * W + 1;
          end
        end
      end else begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_q = p_q; m_r = p_r; m_err = p_err; m_valid = 1;
        end
      end
    end
    m_busy  = (m_rem != 0);
    started = 1;
  end

  always @(posedge clk) begin
    #1;
    if (started) begin
      check("q_bcd",   32'(q_bcd),   32'(m_q));
      check("r_bcd",   32'(r_bcd),   32'(m_r));
      check("err_out", 32'(err_out), 32'(m_err));
      check("valid",   32'(valid),   32'(m_valid));
      check("busy",    32'(busy),    32'(m_busy));
      check("overrun", 32'(overrun), 32'(m_ovr));
    end
  end

  task automatic to_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (m_rem != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("idle_timeout", 32'(1), 32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  int t;

  initial begin
    rst = 1; done_in = 0; error_in = 0; quot_in = '0; rem_in = '0;
    repeat (3) @(negedge clk);
    check("rst_q",     32'(q_bcd), 32'h00);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_busy",  32'(busy),  32'h0);
    rst = 0;
    @(negedge clk);

    // 13/4
    t = cyc; quot_in = 3; rem_in = 1; error_in = 0; done_in = 1;
    to_cyc(t + 1); done_in = 0;
    check("n_busy_t1", 32'(busy), 32'h1);
    to_cyc(t + 9);
    check("n_busy_t9", 32'(busy), 32'h1);
    check("n_valid_t9", 32'(valid), 32'h0);
    to_cyc(t + 10);
    check("n_q",     32'(q_bcd),   32'h03);
    check("n_r",     32'(r_bcd),   32'h01);
    check("n_valid", 32'(valid),   32'h1);
    check("n_err",   32'(err_out), 32'h0);
    check("n_busy",  32'(busy),    32'h0);

    // 15/1
    to_cyc(t + 12);
    t = cyc; quot_in = 15; rem_in = 0; done_in = 1;
    to_cyc(t + 1); done_in = 0;
    to_cyc(t + 10);
    check("max_q", 32'(q_bcd), 32'h15);
    check("max_r", 32'(r_bcd), 32'h00);

    // divide by zero
    to_cyc(t + 12);
    t = cyc; quot_in = 6; rem_in = 5; error_in = 1; done_in = 1;
    to_cyc(t + 1); done_in = 0; error_in = 0;
    check("dz_busy_t1",  32'(busy),  32'h1);
    check("dz_valid_t1", 32'(valid), 32'h0);
    to_cyc(t + 2);
    check("dz_q",     32'(q_bcd),   32'hFF);
    check("dz_r",     32'(r_bcd),   32'hFF);
    check("dz_err",   32'(err_out), 32'h1);
    check("dz_valid", 32'(valid),   32'h1);
    check("dz_busy",  32'(busy),    32'h0);

    // overrun
    to_cyc(t + 4);
    t = cyc; quot_in = 5; rem_in = 2; done_in = 1;
    to_cyc(t + 1); done_in = 0;
    to_cyc(t + 4); quot_in = 9; rem_in = 9; done_in = 1;
    to_cyc(t + 5); done_in = 0;
    check("ov_pulse", 32'(overrun), 32'h1);
    to_cyc(t + 6);
    check("ov_clear", 32'(overrun), 32'h0);
    to_cyc(t + 10);
    check("ov_q", 32'(q_bcd), 32'h05);
    check("ov_r", 32'(r_bcd), 32'h02);
    check("ov_err", 32'(err_out), 32'h0);

    // reset mid-conversion, then back-to-back
    to_cyc(t + 12);
    t = cyc; quot_in = 6; rem_in = 3; done_in = 1;
    to_cyc(t + 1); done_in = 0;
    to_cyc(t + 5); rst = 1;
    to_cyc(t + 6); rst = 0;
    check("mr_q",     32'(q_bcd),   32'h00);
    check("mr_r",     32'(r_bcd),   32'h00);
    check("mr_err",   32'(err_out), 32'h0);
    check("mr_valid", 32'(valid),   32'h0);
    check("mr_busy",  32'(busy),    32'h0);
    to_cyc(t + 8); quot_in = 7; rem_in = 2; done_in = 1;
    to_cyc(t + 9); done_in = 0;
    to_cyc(t + 18);
    check("mr2_q",     32'(q_bcd), 32'h07);
    check("mr2_r",     32'(r_bcd), 32'h02);
    check("mr2_valid", 32'(valid), 32'h1);
    quot_in = 9; rem_in = 4; done_in = 1;
    to_cyc(t + 19); done_in = 0;
    check("b2b_valid", 32'(valid), 32'h0);
    check("b2b_busy",  32'(busy),  32'h1);
    check("b2b_hold_q", 32'(q_bcd), 32'h07);
    to_cyc(t + 28);
    check("b2b_q",     32'(q_bcd), 32'h09);
    check("b2b_r",     32'(r_bcd), 32'h04);
    check("b2b_valid", 32'(valid), 32'h1);

    // exhaustive quotient/remainder sweep with random noise on done_in while busy
    for (int p = 0; p < 256; p++) begin
      logic [7:0] pv;
      wait_idle();
      pv = 8'(p);
      quot_in = pv[7:4]; rem_in = pv[3:0]; error_in = 0; done_in = 1;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (m_rem > 0) begin
          done_in  = ($urandom_range(0, 5) == 0);
          quot_in  = W'($urandom);
          rem_in   = W'($urandom);
          error_in = 1'($urandom);
        end else begin
          break;
        end
      end
      done_in = 0;
    end

    // random transactions including errors and variable gaps
    for (int n = 0; n < 60; n++) begin
      wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      quot_in  = W'($urandom);
      rem_in   = W'($urandom);
      error_in = ($urandom_range(0, 3) == 0);
      done_in  = 1;
      @(negedge clk);
      done_in = 0;
    end
    wait_idle();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
